// File: rtl/dac_reg_spi_arbiter_if.sv
// Request/ack/done handshakes of the two requesters plus the spi_master strobe and
// status lines, bundled for the shared DAC/register SPI channel arbiter.
interface dac_reg_spi_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  dac_req;
  logic [DATA_WIDTH-1:0] dac_data;
  logic                  dac_ack;
  logic                  dac_done;
  logic                  reg_req;
  logic [DATA_WIDTH-1:0] reg_data;
  logic                  reg_ack;
  logic                  reg_done;
  logic                  spi_start;
  logic [DATA_WIDTH-1:0] spi_data;
  logic                  spi_busy;
  logic                  spi_new_data;
  logic [1:0]            cs_dac_reg;
  logic                  spi_timeout;

  // Arbiter side.
  modport slave (
    input  dac_req, dac_data, reg_req, reg_data, spi_busy, spi_new_data,
    output dac_ack, dac_done, reg_ack, reg_done, spi_start, spi_data, cs_dac_reg, spi_timeout
  );

  // Requesters and spi_master side.
  modport master (
    output dac_req, dac_data, reg_req, reg_data, spi_busy, spi_new_data,
    input  dac_ack, dac_done, reg_ack, reg_done, spi_start, spi_data, cs_dac_reg, spi_timeout
  );
endinterface

// File: rtl/dac_reg_spi_arbiter.sv
// Grants the shared DAC/register SPI channel to one requester at a time, framing each
// transfer with CS setup/hold guard times and aborting transfers the SPI master never finishes.
module dac_reg_spi_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic                 clk,
  input logic                 rst,
  dac_reg_spi_arbiter_if.slave bus
);

  localparam logic [1:0] CsNone = 2'b11;
  localparam logic [1:0] CsDac  = 2'b01;
  localparam logic [1:0] CsReg  = 2'b10;

  localparam logic [3:0] SetupInit  = 4'(CS_SETUP);
  localparam logic [3:0] HoldInit   = 4'(CS_HOLD);
  localparam logic [8:0] TimeoutLim = 9'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StSetup, StStart, StWait, StHold, StGap} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [7:0]            tcnt_q, tcnt_d;
  logic                  last_reg_q, last_reg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            cs_q, cs_d;
  logic                  dac_ack_q, dac_ack_d;
  logic                  reg_ack_q, reg_ack_d;
  logic                  dac_done_q, dac_done_d;
  logic                  reg_done_q, reg_done_d;
  logic                  start_q, start_d;
  logic                  timeout_q, timeout_d;
  logic                  grant_reg;

  // Alternating priority: on contention the requester that did not win last time goes first.
  assign grant_reg = bus.reg_req & (~bus.dac_req | ~last_reg_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    last_reg_d = last_reg_q;
    data_d     = data_q;
    cs_d       = cs_q;
    dac_ack_d  = 1'b0;
    reg_ack_d  = 1'b0;
    dac_done_d = 1'b0;
    reg_done_d = 1'b0;
    start_d    = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if ((bus.dac_req | bus.reg_req) & ~bus.spi_busy) begin
          last_reg_d = grant_reg;
          data_d     = grant_reg ? bus.reg_data : bus.dac_data;
          cs_d       = grant_reg ? CsReg : CsDac;
          reg_ack_d  = grant_reg;
          dac_ack_d  = ~grant_reg;
          cnt_d      = SetupInit;
          state_d    = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q <= 4'd1) begin
          start_d = 1'b1;
          state_d = StStart;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StStart: begin
        // The strobe cycle itself counts as the first cycle of the timeout window.
        tcnt_d  = 8'd1;
        state_d = StWait;
      end
      StWait: begin
        if (bus.spi_new_data) begin
          dac_done_d = ~last_reg_q;
          reg_done_d = last_reg_q;
          cnt_d      = HoldInit;
          state_d    = StHold;
        end else if (({1'b0, tcnt_q} + 9'd1) >= TimeoutLim) begin
          timeout_d = 1'b1;
          cs_d      = CsNone;
          state_d   = StGap;
        end else if (tcnt_q != 8'hff) begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      StHold: begin
        if (cnt_q <= 4'd1) begin
          cs_d    = CsNone;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      last_reg_q <= 1'b1;
      data_q     <= '0;
      cs_q       <= CsNone;
      dac_ack_q  <= 1'b0;
      reg_ack_q  <= 1'b0;
      dac_done_q <= 1'b0;
      reg_done_q <= 1'b0;
      start_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      last_reg_q <= last_reg_d;
      data_q     <= data_d;
      cs_q       <= cs_d;
      dac_ack_q  <= dac_ack_d;
      reg_ack_q  <= reg_ack_d;
      dac_done_q <= dac_done_d;
      reg_done_q <= reg_done_d;
      start_q    <= start_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.dac_ack     = dac_ack_q;
  assign bus.reg_ack     = reg_ack_q;
  assign bus.dac_done    = dac_done_q;
  assign bus.reg_done    = reg_done_q;
  assign bus.spi_start   = start_q;
  assign bus.spi_data    = data_q;
  assign bus.cs_dac_reg  = cs_q;
  assign bus.spi_timeout = timeout_q;

endmodule

// File: tb/tb_dac_reg_spi_arbiter.sv
// Bench for dac_reg_spi_arbiter: a transaction-timeline model checked every cycle plus
// directed scenarios with hand-computed latencies.
module tb_dac_reg_spi_arbiter;
  localparam int unsigned DW      = 8;
  localparam int          SETUP   = 2;
  localparam int          HOLD    = 2;
  localparam int          TMO     = 255;
  localparam int          TMO_T   = 10;
  localparam int          SPI_LAT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_reg_spi_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  dac_reg_spi_arbiter_if #(.DATA_WIDTH(DW)) bus_t ();

  dac_reg_spi_arbiter #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  dac_reg_spi_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TMO_T)) dut_t (.clk(clk), .rst(rst), .bus(bus_t));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // spi_master stand-in: busy after the strobe, new_data 16 cycles after it.
  logic rsp_busy = 1'b0, rsp_nd = 1'b0, force_busy = 1'b0, withhold = 1'b0;
  int   rsp_cnt = 0;
  assign bus.spi_busy       = rsp_busy | force_busy;
  assign bus.spi_new_data   = rsp_nd;
  assign bus_t.spi_busy     = 1'b0;
  assign bus_t.spi_new_data = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      rsp_cnt = 0; rsp_busy = 1'b0; rsp_nd = 1'b0;
    end else if (bus.spi_start && !withhold) begin
      rsp_cnt = SPI_LAT; rsp_busy = 1'b1; rsp_nd = 1'b0;
    end else if (rsp_cnt > 0) begin
      rsp_nd = (rsp_cnt == 1);
      if (rsp_cnt == 1) rsp_busy = 1'b0;
      rsp_cnt--;
    end else begin
      rsp_nd = 1'b0;
    end
  end

  // Timeline model: each grant schedules its start, completion window and CS release.
  logic       m_dac_ack = 0, m_reg_ack = 0, m_dac_done = 0, m_reg_done = 0;
  logic       m_start = 0, m_tmo = 0;
  logic [1:0] m_cs = 2'b11;
  logic [7:0] m_data = 8'h00;
  bit         m_active = 0, m_hold = 0, m_last_reg = 1, take_reg;
  int         m_n = 0, m_t_start = 0, m_t_rel = 0, m_next_ok = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    m_dac_ack = 0; m_reg_ack = 0; m_dac_done = 0; m_reg_done = 0; m_start = 0; m_tmo = 0;
    if (rst) begin
      m_cs = 2'b11; m_data = 8'h00; m_active = 0; m_hold = 0; m_last_reg = 1;
      m_n = 0; m_next_ok = 0;
    end else begin
      m_n++;
      if (!m_active) begin
        if (m_n >= m_next_ok && (bus.dac_req || bus.reg_req) && !bus.spi_busy) begin
          take_reg   = (bus.dac_req && bus.reg_req) ? !m_last_reg : bus.reg_req;
          m_last_reg = take_reg;
          m_data     = take_reg ? bus.reg_data : bus.dac_data;
          m_cs       = take_reg ? 2'b10 : 2'b01;
          m_reg_ack  = take_reg;
          m_dac_ack  = !take_reg;
          m_active   = 1; m_hold = 0;
          m_t_start  = m_n + SETUP;
        end
      end else if (!m_hold) begin
        if (m_n == m_t_start) begin
          m_start = 1;
        end else if (m_n >= m_t_start + 2 && bus.spi_new_data) begin
          m_dac_done = !m_last_reg; m_reg_done = m_last_reg;
          m_hold = 1; m_t_rel = m_n + HOLD;
        end else if (m_n == m_t_start + TMO) begin
          m_tmo = 1; m_cs = 2'b11; m_active = 0; m_next_ok = m_n + 2;
        end
      end else if (m_n == m_t_rel) begin
        m_cs = 2'b11; m_active = 0; m_next_ok = m_n + 2;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("cmp dac_ack", bus.dac_ack, m_dac_ack);
      check("cmp reg_ack", bus.reg_ack, m_reg_ack);
      check("cmp dac_done", bus.dac_done, m_dac_done);
      check("cmp reg_done", bus.reg_done, m_reg_done);
      check("cmp spi_start", bus.spi_start, m_start);
      check("cmp spi_timeout", bus.spi_timeout, m_tmo);
      check("cmp cs_dac_reg", bus.cs_dac_reg, m_cs);
      check("cmp spi_data", bus.spi_data, m_data);
    end
  end

  // Pulse counters and CS-change recorder.
  int dac_ack_cnt = 0, reg_ack_cnt = 0, dac_done_cnt = 0, reg_done_cnt = 0, t_done_cnt = 0;
  bit rec_en = 0;
  logic [1:0] rec_q[$];
  logic [1:0] rec_last = 2'b11;
  int rec_run = 0, rec_min = 1000;

  initial forever begin
    @(posedge clk);
    #2;
    if (bus.dac_ack) dac_ack_cnt++;
    if (bus.reg_ack) reg_ack_cnt++;
    if (bus.dac_done) dac_done_cnt++;
    if (bus.reg_done) reg_done_cnt++;
    if (bus_t.dac_done) t_done_cnt++;
    if (rec_en && bus.cs_dac_reg != rec_last) begin
      if (bus.cs_dac_reg != 2'b11 && rec_q.size() > 0 && rec_run < rec_min) rec_min = rec_run;
      rec_q.push_back(bus.cs_dac_reg);
      rec_last = bus.cs_dac_reg;
    end
    if (bus.cs_dac_reg == 2'b11) rec_run++;
    else rec_run = 0;
  end

  function automatic bit probe(input int sel);
    case (sel)
      0:       return bus.dac_ack;
      1:       return bus.reg_ack;
      2:       return bus.spi_start;
      3:       return bus.dac_done;
      4:       return bus.reg_done;
      5:       return bus.cs_dac_reg == 2'b11;
      6:       return bus_t.dac_ack;
      7:       return bus_t.spi_start;
      8:       return bus_t.spi_timeout;
      9:       return bus.spi_timeout;
      default: return bus.dac_ack | bus.reg_ack;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int sel, input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (probe(sel)) begin
        at = cyc;
        break;
      end
    end
    n_cmp++;
    if (at < 0) begin
      n_bad++;
      $display("FAIL %s: event absent within %0d cycles", nm, bound);
    end
  endtask

  int a, s, d, c, q, r, b, c0, base;
  int order[3];
  logic [1:0] exp_cs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.dac_req = 0; bus.reg_req = 0; bus.dac_data = '0; bus.reg_data = '0;
    bus_t.dac_req = 0; bus_t.reg_req = 0; bus_t.dac_data = '0; bus_t.reg_data = '0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    check("rst cs", bus.cs_dac_reg, 2'b11);
    check("rst spi_data", bus.spi_data, 8'h00);
    check("rst spi_start", bus.spi_start, 1'b0);
    check("rst acks", {bus.dac_ack, bus.reg_ack}, 2'b00);
    check("rst done/timeout", {bus.dac_done, bus.reg_done, bus.spi_timeout}, 3'b000);
    rst = 0;

    // Single DAC transfer.
    @(negedge clk);
    bus.dac_data = 8'hA5; bus.dac_req = 1; c0 = cyc;
    wait_for("t1 dac_ack", 0, 10, a);
    check("t1 ack latency", a - c0, 1);
    check("t1 cs", bus.cs_dac_reg, 2'b01);
    bus.dac_req = 0;
    wait_for("t1 spi_start", 2, 10, s);
    check("t1 start after ack", s - a, 2);
    check("t1 spi_data", bus.spi_data, 8'hA5);
    wait_for("t1 dac_done", 3, 40, d);
    check("t1 done after start", d - s, SPI_LAT + 1);
    wait_for("t1 cs release", 5, 10, c);
    check("t1 cs release after done", c - d, HOLD);
    repeat (4) @(negedge clk);

    // Contention from reset, three transfers.
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    bus.dac_data = 8'hA5; bus.reg_data = 8'h42;
    rec_last = 2'b11; rec_run = 0; rec_en = 1;
    bus.dac_req = 1; bus.reg_req = 1;
    for (int g = 0; g < 3; g++) begin
      wait_for("t2 ack", 10, 60, a);
      order[g] = bus.reg_ack ? 1 : 0;
      check("t2 spi_data", bus.spi_data, bus.reg_ack ? 8'h42 : 8'hA5);
      if (bus.reg_ack) bus.reg_req = 0;
      else bus.dac_req = 0;
      if (g == 2) begin
        bus.dac_req = 0; bus.reg_req = 0;
      end else begin
        @(negedge clk);
        bus.dac_req = 1; bus.reg_req = 1;
      end
    end
    wait_for("t2 final release", 5, 60, c);
    repeat (2) @(negedge clk);
    rec_en = 0;
    check("t2 grant 0", order[0], 0);
    check("t2 grant 1", order[1], 1);
    check("t2 grant 2", order[2], 0);
    exp_cs = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
    check("t2 cs changes", rec_q.size(), 6);
    for (int i = 0; i < 6 && i < rec_q.size(); i++) check("t2 cs seq", rec_q[i], exp_cs[i]);
    check("t2 cs high between", rec_min >= 1, 1);

    // REG request during a DAC transfer waits for GAP.
    @(negedge clk);
    bus.dac_data = 8'h81; bus.dac_req = 1;
    wait_for("t3 dac_ack", 0, 10, a);
    bus.dac_req = 0;
    wait_for("t3 spi_start", 2, 10, s);
    repeat (3) @(negedge clk);
    base = reg_ack_cnt;
    bus.reg_data = 8'h5A; bus.reg_req = 1;
    wait_for("t3 dac_done", 3, 40, d);
    check("t3 no early reg_ack", reg_ack_cnt - base, 0);
    wait_for("t3 reg_ack", 1, 20, r);
    check("t3 reg_ack after done", r - d, HOLD + 2);
    check("t3 cs", bus.cs_dac_reg, 2'b10);
    check("t3 spi_data", bus.spi_data, 8'h5A);
    bus.reg_req = 0;
    wait_for("t3 reg_done", 4, 40, d);
    wait_for("t3 cs release", 5, 10, c);
    repeat (2) @(negedge clk);

    // Stray busy in IDLE blocks the grant.
    force_busy = 1; bus.dac_data = 8'h11; bus.dac_req = 1; base = dac_ack_cnt;
    repeat (6) @(negedge clk);
    check("t6 no ack while busy", dac_ack_cnt - base, 0);
    force_busy = 0; b = cyc;
    wait_for("t6 dac_ack", 0, 10, a);
    check("t6 ack after busy drop", a - b, 1);
    bus.dac_req = 0;
    wait_for("t6 dac_done", 3, 40, d);
    wait_for("t6 cs release", 5, 10, c);
    repeat (2) @(negedge clk);

    // Main instance timeout at the full 255-cycle limit.
    withhold = 1; base = dac_done_cnt;
    bus.dac_data = 8'hC3; bus.dac_req = 1;
    wait_for("tm dac_ack", 0, 10, a);
    bus.dac_req = 0;
    wait_for("tm spi_start", 2, 10, s);
    wait_for("tm spi_timeout", 9, 300, q);
    check("tm timeout after start", q - s, TMO);
    check("tm cs", bus.cs_dac_reg, 2'b11);
    check("tm no done", dac_done_cnt - base, 0);
    withhold = 0;
    repeat (3) @(negedge clk);

    // Short-timeout instance.
    bus_t.dac_data = 8'h77; bus_t.dac_req = 1;
    wait_for("tt dac_ack", 6, 10, a);
    check("tt cs", bus_t.cs_dac_reg, 2'b01);
    bus_t.dac_req = 0;
    wait_for("tt spi_start", 7, 10, s);
    check("tt start after ack", s - a, 2);
    wait_for("tt spi_timeout", 8, 30, q);
    check("tt timeout after start", q - s, TMO_T);
    check("tt cs at timeout", bus_t.cs_dac_reg, 2'b11);
    bus_t.dac_req = 1;
    @(negedge clk);
    check("tt cs next cycle", bus_t.cs_dac_reg, 2'b11);
    wait_for("tt regrant", 6, 10, a);
    check("tt regrant latency", a - q, 2);
    check("tt spi_data", bus_t.spi_data, 8'h77);
    bus_t.dac_req = 0;
    check("tt no done", t_done_cnt, 0);
    repeat (2) @(negedge clk);

    // Reset during SETUP of a REG transfer.
    bus.reg_data = 8'h42; bus.reg_req = 1;
    wait_for("t5 reg_ack", 1, 10, a);
    bus.reg_req = 0; base = reg_done_cnt;
    rst = 1;
    #1;
    check("t5 cs on reset", bus.cs_dac_reg, 2'b11);
    check("t5 start on reset", bus.spi_start, 1'b0);
    check("t5 ack on reset", bus.reg_ack, 1'b0);
    check("t5 data on reset", bus.spi_data, 8'h00);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (30) @(negedge clk);
    check("t5 no reg_done", reg_done_cnt - base, 0);
    bus.dac_data = 8'h99; bus.dac_req = 1; c0 = cyc;
    wait_for("t5 dac_ack", 0, 10, a);
    check("t5 ack latency", a - c0, 1);
    check("t5 cs", bus.cs_dac_reg, 2'b01);
    bus.dac_req = 0;
    wait_for("t5 dac_done", 3, 40, d);
    wait_for("t5 cs release", 5, 10, c);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dac_reg_spi_arbiter.md
# dac_reg_spi_arbiter

Arbiter and sequencer for the shared DAC/register SPI channel. It sits between two requesters and the single 8-bit `spi_master` instance that drives `dac_reg_sck`/`dac_reg_mosi`. The two requesters are the sine-generator sample path, which writes DAC codes, and the measurement FSM, which writes `{diap, keys}` to the key/range register. The block grants one transfer at a time, drives the active-low `cs_dac_reg` select with setup and hold guard times, reports completion to the winning requester, and recovers if the SPI master stalls.

## Interface
Parameters:
- `DATA_WIDTH`, 8: SPI word width; must match `spi_master`.
- `CS_SETUP`, 2: cycles from CS assertion to `spi_start`, range 1..15.
- `CS_HOLD`, 2: cycles from `spi_new_data` to CS release, range 1..15.
- `TIMEOUT`, 255: maximum cycles spent in WAIT before aborting, range 1..255.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `dac_req`, in, 1: DAC transfer request; held high until `dac_ack`.
- `dac_data`, in, DATA_WIDTH: DAC word; must be valid while `dac_req` is high.
- `dac_ack`, out, 1: 1-cycle pulse; DAC word latched.
- `dac_done`, out, 1: 1-cycle pulse; DAC transfer complete.
- `reg_req`, in, 1: register transfer request; held high until `reg_ack`.
- `reg_data`, in, DATA_WIDTH: register word `{diap[2:0], keys[4:0]}`.
- `reg_ack`, out, 1: 1-cycle pulse; register word latched.
- `reg_done`, out, 1: 1-cycle pulse; register transfer complete.
- `spi_start`, out, 1: 1-cycle start strobe to `spi_master`.
- `spi_data`, out, DATA_WIDTH: word presented to `spi_master.data_in`.
- `spi_busy`, in, 1: `spi_master` busy.
- `spi_new_data`, in, 1: `spi_master` transfer-complete pulse.
- `cs_dac_reg`, out, 2: 2'b11 = none, 2'b01 = DAC, 2'b10 = REG.
- `spi_timeout`, out, 1: 1-cycle pulse; transfer aborted.

## Operation
- All outputs are registered.
- Reset values: `cs_dac_reg` = 2'b11; `spi_start`, all acks, all dones and `spi_timeout` = 0; `spi_data` = 0; state = IDLE; `last_grant` = REG.
- States: IDLE → SETUP → START → WAIT → HOLD → GAP → IDLE.
- IDLE:
  - If `dac_req` or `reg_req` is high and `spi_busy` is 0, select an owner.
  - Only one requester high: it wins.
  - Both high: the requester that is not `last_grant` wins (alternating priority). After reset, DAC wins a tie.
  - On the selection edge: latch the owner's data into `spi_data`, pulse the owner's ack, drive `cs_dac_reg` to the owner's code, update `last_grant`, load the counter with CS_SETUP, and go to SETUP.
  - If `spi_busy` is high in IDLE (stray start), wait; issue no grant.
- SETUP: decrement the counter each cycle; when it reaches 1, go to START.
- START: assert `spi_start` for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - On `spi_new_data`: pulse the owner's done, load the counter with CS_HOLD, go to HOLD.
  - When the timeout counter reaches TIMEOUT: pulse `spi_timeout`, do not pulse done, go to GAP. CS is released immediately on this path.
- HOLD: decrement the counter; at 1, set `cs_dac_reg` to 2'b11 and go to GAP.
- GAP: one cycle with CS deasserted, then return to IDLE. This gives a minimum CS-high time of 1 cycle.
- `spi_data` is held constant from the ack until the next grant.
- Requests arriving outside IDLE are not lost: a request stays high until its ack and is arbitrated on the next IDLE.
- A requester must not reassert in the same cycle its ack is visible; requests are sampled only in IDLE.

## Timing
- Let edge E0 be the selection edge.
  - Ack and CS change after E0.
  - `spi_start` is high in the cycle following edge E0+CS_SETUP.
  - Done is high in the cycle after the edge that samples `spi_new_data`.
  - CS returns to 11 CS_HOLD edges after that.
  - The next grant is possible 1 cycle (GAP) after CS release.
- Overhead per transfer, excluding SPI time: CS_SETUP + 1 + CS_HOLD + 1 cycles.
- `dac_req` and `reg_req` high in the same cycle as CS release: the earliest grant is after GAP. The alternating rule applies.
- Reset mid-transfer: all outputs return to reset values asynchronously. No done is issued, and the in-flight word is dropped. `spi_master` shares `rst`.
- Timeout counter is 8 bits and saturates. It is used only in WAIT.

## Test plan
- Single DAC request, `dac_data` = 8'hA5, defaults:
  - `dac_ack` after E0; `cs_dac_reg` = 01.
  - `spi_start` 2 cycles later with `spi_data` = A5.
  - Model `spi_new_data` 16 cycles after start → `dac_done` pulse; CS = 11 after 2 cycles.
- `dac_req` and `reg_req` together from reset (reg_data = 8'h42), held across three transfers:
  - Grant order is DAC, REG, DAC.
  - `cs_dac_reg` sequence is 01, 11, 10, 11, 01, 11, with at least 1 cycle at 11 between transfers.
- `reg_req` asserted while a DAC transfer is in WAIT:
  - No `reg_ack` until GAP has completed.
  - `reg_ack` on the first IDLE edge; CS = 10.
- `spi_new_data` withheld, TIMEOUT = 10:
  - `spi_timeout` pulses 10 cycles after `spi_start`; no `dac_done`.
  - CS = 11 next cycle; the block returns to IDLE and accepts a new request.
- `rst` asserted during SETUP of a REG transfer:
  - Immediately `cs_dac_reg` = 11 and `spi_start` = 0; no `reg_done`.
  - After release, the next request is granted normally.
- `spi_busy` forced high in IDLE with `dac_req` high: no ack while busy; ack on the first edge after busy drops.
